axi_lite_responder: RTL
=======================

AXI_LITE_RESPONDER -- requirements
Module: axi_lite_responder

Interface
REQ-001 The block SHALL take parameter NUM_REGS, default 8, giving the number of 32-bit registers (1..1024).
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 32, giving the awaddr/araddr width.
REQ-003 Ports SHALL be, one per line, as follows:
- s_axi_aclk  in  1  the only clock
- s_axi_aresetn  in  1  asynchronous, active-low reset
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awprot  in  3  ignored
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte enables
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake
- s_axi_bresp  out  2  write response
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arprot  in  3  ignored
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake
- reg_out  out  NUM_REGS*32  all register contents; register i occupies bits [32i+31:32i]
- wr_stb  out  NUM_REGS  one-cycle pulse when register i is written
REQ-004 One clock (s_axi_aclk); reset s_axi_aresetn is asynchronous, active-low.

Function
REQ-005 The register index SHALL be addr[11:2]; addr[1:0] and addr above bit 11 SHALL be ignored.
REQ-006 AW and W SHALL be accepted independently and in either order, each into its own one-entry holding register.
- awready = AW holding register empty.
- wready = W holding register empty.
REQ-007 Commit occurs at the first edge at which both holding registers are full and (bvalid=0 or bready=1). At that edge:
- both holding registers are cleared;
- bvalid is set;
- an in-range target is updated byte-wise under wstrb.
REQ-008 For the default configuration, with AW and W accepted at edge N and bready=1, commit, bvalid=1 and wr_stb[i]=1 SHALL occur at edge N+1.
REQ-009 bresp SHALL be 2'b00 (OKAY) for index < NUM_REGS. Otherwise it is 2'b10 (SLVERR), no register changes and no wr_stb pulses.
REQ-010 bvalid SHALL hold, with bresp stable, until bready is sampled high; at most one write response is outstanding.
REQ-011 wr_stb[i] SHALL pulse at a commit to in-range register i even when wstrb=4'h0.
REQ-012 arready SHALL equal not(rvalid).
REQ-013 On the AR handshake at edge N:
- rdata and rresp are registered at edge N;
- rvalid=1 from edge N;
- rdata and rresp stay stable until rready is sampled high.
REQ-014 Out-of-range reads SHALL return rdata=0 and rresp=2'b10.
REQ-015 When a read samples a register at the same edge a commit writes it, the read SHALL return the pre-write value.
REQ-016 Read and write channels SHALL operate concurrently without mutual stalls.

Reset
REQ-017 While s_axi_aresetn=0, the following SHALL be 0:
- all registers;
- both holding registers, leaving awready=wready=arready=1 after release;
- bvalid, rvalid, bresp, rresp, rdata and wr_stb.
REQ-018 A reset asserted mid-transaction SHALL discard held AW/W data and pending responses, with no partial register update.

Structure
REQ-019 Shared package axi_lite_pkg SHALL hold:
- RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
- ADDR_LSB=2 and IDX_MSB=11;
- a byte-merge function (old, new, strb).
REQ-020 The block SHALL be a single module with no sub-modules.

Verification
REQ-021 W at cycle 0, then AW 0x43c00004 at cycle 1, data 0xF, bready=1 -> reg_out[63:32]=0xF, wr_stb=8'h02 for one cycle, bresp=OKAY.
REQ-022 AW 0x43c00008 and W 0x11223344 in the same cycle, wstrb=4'b0101, prior value 0 -> register 2 = 0x00220044.
REQ-023 bready=0 for 5 cycles after the first write; issue a second write -> bvalid stays high, the second commit is delayed until bready=1, no lost write.
REQ-024 Write to 0x43c00020 (index 8) -> bresp=SLVERR, reg_out unchanged, wr_stb=0; read of 0x43c00020 -> rdata=0, rresp=SLVERR.
REQ-025 Read 0x43c00004 with rready=0 for 3 cycles -> rvalid and rdata=0xF stable, arready=0 until the R handshake.
REQ-026 Assert s_axi_aresetn=0 while W is held but AW is not -> after release, awready=wready=1 and all registers are 0.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, register index field, byte merge.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int ADDR_LSB = 2;
   localparam int IDX_MSB  = 11;
   localparam int IDX_W    = IDX_MSB - ADDR_LSB + 1;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axi_lite_responder.sv
// AXI4-Lite register file responder: independent AW/W holding registers,
// single outstanding B and R responses, flat register export with write strobes.
module axi_lite_responder
   import axi_lite_pkg::*;
#(
   parameter int NUM_REGS   = 8,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                     s_axi_aclk,
   input  logic                     s_axi_aresetn,
   input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
   input  logic [2:0]               s_axi_awprot,
   input  logic                     s_axi_awvalid,
   output logic                     s_axi_awready,
   input  logic [31:0]              s_axi_wdata,
   input  logic [3:0]               s_axi_wstrb,
   input  logic                     s_axi_wvalid,
   output logic                     s_axi_wready,
   output logic [1:0]               s_axi_bresp,
   output logic                     s_axi_bvalid,
   input  logic                     s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
   input  logic [2:0]               s_axi_arprot,
   input  logic                     s_axi_arvalid,
   output logic                     s_axi_arready,
   output logic [31:0]              s_axi_rdata,
   output logic [1:0]               s_axi_rresp,
   output logic                     s_axi_rvalid,
   input  logic                     s_axi_rready,
   output logic [NUM_REGS*32-1:0]   reg_out,
   output logic [NUM_REGS-1:0]      wr_stb
);

   localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W+1)'(NUM_REGS);

   logic             aw_full, w_full;
   logic [IDX_W-1:0] aw_idx, ar_idx;
   logic [31:0]      w_data, rd_val;
   logic [3:0]       w_strb;
   logic             commit, wr_in_range, rd_in_range;
   logic [31:0]      regs [NUM_REGS];

   // Protection bits and address bits outside the index field carry no meaning here.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

   assign s_axi_awready = !aw_full;
   assign s_axi_wready  = !w_full;
   assign s_axi_arready = !s_axi_rvalid;

   assign commit      = aw_full && w_full && (!s_axi_bvalid || s_axi_bready);
   assign wr_in_range = {1'b0, aw_idx} < NUM_REGS_L;
   assign ar_idx      = s_axi_araddr[IDX_MSB:ADDR_LSB];
   assign rd_in_range = {1'b0, ar_idx} < NUM_REGS_L;

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ar_idx == IDX_W'(i)) rd_val = regs[i];
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         aw_full      <= 1'b0;
         w_full       <= 1'b0;
         aw_idx       <= '0;
         w_data       <= '0;
         w_strb       <= '0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
         s_axi_rresp  <= RESP_OKAY;
         wr_stb       <= '0;
      end else begin
         if (commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
         end else begin
            if (s_axi_awvalid && !aw_full) begin
               aw_full <= 1'b1;
               aw_idx  <= s_axi_awaddr[IDX_MSB:ADDR_LSB];
            end
            if (s_axi_wvalid && !w_full) begin
               w_full <= 1'b1;
               w_data <= s_axi_wdata;
               w_strb <= s_axi_wstrb;
            end
         end

         // bresp only moves at a commit, so it stays put while bvalid waits on bready.
         if (commit) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
         end else if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
         end

         for (int i = 0; i < NUM_REGS; i++) begin
            wr_stb[i] <= commit && wr_in_range && (aw_idx == IDX_W'(i));
         end

         if (s_axi_arvalid && !s_axi_rvalid) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_in_range ? rd_val : 32'h0;
            s_axi_rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
         end else if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && wr_in_range && (aw_idx == IDX_W'(i))) begin
               regs[i] <= byte_merge(regs[i], w_data, w_strb);
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
      assign reg_out[32*g +: 32] = regs[g];
   end

endmodule
